// File: rtl/start_fifo_srl_ctrl.sv
// Shift-register FIFO with first-word-fall-through output and registered full/empty flags.
// Optional macro START_FIFO_OCCUPANCY_EN adds the if_num_data_valid occupancy output.
module start_fifo_srl_ctrl #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH      = 11
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n
`ifdef START_FIFO_OCCUPANCY_EN
   ,output logic [ADDR_WIDTH-1:0] if_num_data_valid
`endif
);

    localparam logic [ADDR_WIDTH-1:0] DEPTH_CNT = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] cnt_d;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  push;
    logic                  pop;

    // Flags decode only the registered count, so no input reaches them combinationally.
    assign if_full_n  = (cnt_q != DEPTH_CNT);
    assign if_empty_n = (cnt_q != '0);

    // Gating with ap_rst_n keeps the storage still on edges seen while reset is held.
    assign push = if_write & if_write_ce & if_full_n  & ap_rst_n;
    assign pop  = if_read  & if_read_ce  & if_empty_n & ap_rst_n;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + ONE;
            2'b01:   cnt_d = cnt_q - ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (push) begin
            mem_q[0] <= if_din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign rd_addr = (cnt_q == '0) ? '0 : (cnt_q - ONE);

    // Oldest word sits at entry cnt-1; compare-based mux stays in range for any ADDR_WIDTH.
    always_comb begin
        if_dout = mem_q[0];
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (rd_addr == ADDR_WIDTH'(i)) begin
                if_dout = mem_q[i];
            end
        end
    end

`ifdef START_FIFO_OCCUPANCY_EN
    assign if_num_data_valid = cnt_q;
`endif

endmodule

// File: tb/tb_start_fifo_srl_ctrl.sv
// Scoreboard bench for start_fifo_srl_ctrl: expected words queued on accepted pushes, compared on pops.
module tb_start_fifo_srl_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 11;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          if_write_ce = 1'b0;
    logic          if_write = 1'b0;
    logic [DW-1:0] if_din = '0;
    logic          if_full_n;
    logic          if_read_ce = 1'b0;
    logic          if_read = 1'b0;
    logic [DW-1:0] if_dout;
    logic          if_empty_n;
`ifdef START_FIFO_OCCUPANCY_EN
    logic [AW-1:0] if_num_data_valid;
`endif

    logic [DW-1:0] exp_q [$];
    int            n_cmp = 0;
    int            n_err = 0;

    start_fifo_srl_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .if_write_ce (if_write_ce),
        .if_write    (if_write),
        .if_din      (if_din),
        .if_full_n   (if_full_n),
        .if_read_ce  (if_read_ce),
        .if_read     (if_read),
        .if_dout     (if_dout),
        .if_empty_n  (if_empty_n)
`ifdef START_FIFO_OCCUPANCY_EN
       ,.if_num_data_valid (if_num_data_valid)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one cycle; updates the scoreboard and returns the word seen before the edge.
    task automatic apply(input logic w, input logic wce, input logic r, input logic rce,
                         input logic [DW-1:0] d, output bit popped,
                         output logic [DW-1:0] exp_w, output logic [DW-1:0] got_w);
        bit push_ok;
        bit pop_ok;
        push_ok = w && wce && (exp_q.size() != DEPTH);
        pop_ok  = r && rce && (exp_q.size() != 0);
        popped  = pop_ok;
        exp_w   = '0;
        got_w   = if_dout;
        if (pop_ok)  exp_w = exp_q.pop_front();
        if (push_ok) exp_q.push_back(d);
        if_write = w; if_write_ce = wce; if_read = r; if_read_ce = rce; if_din = d;
        @(posedge ap_clk);
        #1;
        if_write = 1'b0; if_write_ce = 1'b0; if_read = 1'b0; if_read_ce = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        n_cmp++;
        if ({if_full_n, if_empty_n} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_flags: got full_n,empty_n=%b required 10", {if_full_n, if_empty_n});
        end
`ifdef START_FIFO_OCCUPANCY_EN
        n_cmp++;
        if (if_num_data_valid !== '0) begin
            n_err++;
            $display("FAIL reset_count: got %0d required 0", if_num_data_valid);
        end
`endif
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic test_drain();
        bit            p;
        logic [DW-1:0] e;
        logic [DW-1:0] g;
        for (int i = 0; i < int'(DEPTH) + 2 && exp_q.size() != 0; i++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b1, '0, p, e, g);
            n_cmp++;
            if (!p || g !== e) begin
                n_err++;
                $display("FAIL drain_data: got %0h required %0h (popped=%0d)", g, e, p);
            end
            n_cmp++;
            if ({if_full_n, if_empty_n} !== {exp_q.size() != DEPTH, exp_q.size() != 0}) begin
                n_err++;
                $display("FAIL drain_flags: got %b required %b", {if_full_n, if_empty_n},
                         {exp_q.size() != DEPTH, exp_q.size() != 0});
            end
        end
        n_cmp++;
        if ({if_full_n, if_empty_n} !== 2'b10 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_empty: got flags %b required 10, model size %0d", {if_full_n, if_empty_n}, exp_q.size());
        end
`ifdef START_FIFO_OCCUPANCY_EN
        n_cmp++;
        if (if_num_data_valid !== '0) begin
            n_err++;
            $display("FAIL drain_count: got %0d required 0", if_num_data_valid);
        end
`endif
    endtask

    task automatic test_basic();
        bit            p;
        logic [DW-1:0] e;
        logic [DW-1:0] g;
        logic [DW-1:0] pat [3] = '{8'h01, 8'h00, 8'h01};
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0, pat[i], p, e, g);
            n_cmp++;
            if (if_empty_n !== 1'b1 || if_dout !== exp_q[0]) begin
                n_err++;
                $display("FAIL basic_push%0d: got empty_n=%b dout=%0h required 1 %0h", i, if_empty_n, if_dout, exp_q[0]);
            end
        end
        n_cmp++;
        if ({if_full_n, if_empty_n} !== 2'b11 || if_dout !== 8'h01) begin
            n_err++;
            $display("FAIL basic_after3: got flags %b dout %0h required 11 01", {if_full_n, if_empty_n}, if_dout);
        end
`ifdef START_FIFO_OCCUPANCY_EN
        n_cmp++;
        if (if_num_data_valid !== AW'(3)) begin
            n_err++;
            $display("FAIL basic_count: got %0d required 3", if_num_data_valid);
        end
`endif
    endtask

    task automatic test_fill();
        bit            p;
        logic [DW-1:0] e;
        logic [DW-1:0] g;
        for (int i = 0; i < int'(DEPTH); i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0, DW'($urandom_range(255)), p, e, g);
            n_cmp++;
            if ({if_full_n, if_empty_n} !== {exp_q.size() != DEPTH, 1'b1}) begin
                n_err++;
                $display("FAIL fill_flags%0d: got %b required %b", i, {if_full_n, if_empty_n}, {exp_q.size() != DEPTH, 1'b1});
            end
        end
        apply(1'b1, 1'b1, 1'b0, 1'b0, 8'hEE, p, e, g);
        n_cmp++;
        if ({if_full_n, if_empty_n} !== 2'b01 || if_dout !== exp_q[0]) begin
            n_err++;
            $display("FAIL fill_overflow: got flags %b dout %0h required 01 %0h", {if_full_n, if_empty_n}, if_dout, exp_q[0]);
        end
`ifdef START_FIFO_OCCUPANCY_EN
        n_cmp++;
        if (if_num_data_valid !== AW'(DEPTH)) begin
            n_err++;
            $display("FAIL fill_count: got %0d required %0d", if_num_data_valid, DEPTH);
        end
`endif
    endtask

    task automatic test_back_to_back();
        bit            p;
        logic [DW-1:0] e;
        logic [DW-1:0] g;
        for (int i = 0; i < 5; i++) apply(1'b1, 1'b1, 1'b0, 1'b0, DW'(8'h30 + i), p, e, g);
        for (int i = 0; i < 20; i++) begin
            apply(1'b1, 1'b1, 1'b1, 1'b1, DW'($urandom_range(255)), p, e, g);
            n_cmp++;
            if (!p || g !== e || {if_full_n, if_empty_n} !== 2'b11 || if_dout !== exp_q[0]) begin
                n_err++;
                $display("FAIL b2b_%0d: got pop %0h flags %b head %0h required %0h 11 %0h",
                         i, g, {if_full_n, if_empty_n}, if_dout, e, exp_q[0]);
            end
`ifdef START_FIFO_OCCUPANCY_EN
            n_cmp++;
            if (if_num_data_valid !== AW'(5)) begin
                n_err++;
                $display("FAIL b2b_count%0d: got %0d required 5", i, if_num_data_valid);
            end
`endif
        end
    endtask

    task automatic test_corner();
        bit            p;
        logic [DW-1:0] e;
        logic [DW-1:0] g;
        apply(1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, p, e, g);
        n_cmp++;
        if ({if_full_n, if_empty_n} !== 2'b11 || if_dout !== 8'hA5 || exp_q.size() != 1) begin
            n_err++;
            $display("FAIL corner_empty: got flags %b dout %0h required 11 a5", {if_full_n, if_empty_n}, if_dout);
        end
        for (int i = 0; i < int'(DEPTH) - 1; i++) apply(1'b1, 1'b1, 1'b0, 1'b0, DW'(8'h60 + i), p, e, g);
        n_cmp++;
        if (if_full_n !== 1'b0) begin
            n_err++;
            $display("FAIL corner_full: got full_n=%b required 0", if_full_n);
        end
        apply(1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, p, e, g);
        n_cmp++;
        if (!p || g !== e || {if_full_n, if_empty_n} !== 2'b11 || exp_q.size() != DEPTH - 1) begin
            n_err++;
            $display("FAIL corner_fullrw: got pop %0h flags %b required %0h 11", g, {if_full_n, if_empty_n}, e);
        end
`ifdef START_FIFO_OCCUPANCY_EN
        n_cmp++;
        if (if_num_data_valid !== AW'(DEPTH - 1)) begin
            n_err++;
            $display("FAIL corner_count: got %0d required %0d", if_num_data_valid, DEPTH - 1);
        end
`endif
    endtask

    task automatic test_reset_mid();
        bit            p;
        logic [DW-1:0] e;
        logic [DW-1:0] g;
        for (int i = 0; i < 7; i++) apply(1'b1, 1'b1, 1'b0, 1'b0, DW'(8'h90 + i), p, e, g);
        #3;
        ap_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({if_full_n, if_empty_n} !== 2'b10) begin
            n_err++;
            $display("FAIL rstmid_async: got flags %b required 10", {if_full_n, if_empty_n});
        end
        exp_q.delete();
        if_write = 1'b1; if_write_ce = 1'b1; if_din = 8'h77;
        @(posedge ap_clk);
        #1;
        if_write = 1'b0; if_write_ce = 1'b0;
        n_cmp++;
        if ({if_full_n, if_empty_n} !== 2'b10) begin
            n_err++;
            $display("FAIL rstmid_held: got flags %b required 10", {if_full_n, if_empty_n});
        end
        ap_rst_n = 1'b1;
        apply(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, p, e, g);
        n_cmp++;
        if (if_empty_n !== 1'b1 || if_dout !== 8'h00) begin
            n_err++;
            $display("FAIL rstmid_first: got empty_n=%b dout=%0h required 1 00", if_empty_n, if_dout);
        end
    endtask

    task automatic test_write_ce();
        bit            p;
        logic [DW-1:0] e;
        logic [DW-1:0] g;
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b1, 1'b0, 1'b0, DW'(8'hC0 + i), p, e, g);
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b0, 1'b1, 1'b0, DW'($urandom_range(255)), p, e, g);
            n_cmp++;
            if ({if_full_n, if_empty_n} !== 2'b11 || if_dout !== exp_q[0] || exp_q.size() != 3) begin
                n_err++;
                $display("FAIL ce_block%0d: got flags %b dout %0h required 11 %0h", i, {if_full_n, if_empty_n}, if_dout, exp_q[0]);
            end
`ifdef START_FIFO_OCCUPANCY_EN
            n_cmp++;
            if (if_num_data_valid !== AW'(3)) begin
                n_err++;
                $display("FAIL ce_count%0d: got %0d required 3", i, if_num_data_valid);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drain();
        test_fill();
        test_drain();
        test_back_to_back();
        test_drain();
        test_corner();
        test_drain();
        test_reset_mid();
        test_drain();
        test_write_ce();
        test_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
